// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D memory port arbiter
// Contents: state_e (IDLE, ACCESS), owner_e (OWN_I, OWN_D), CNT_W latency/streak counter width.
package mem_arb_pkg;
   localparam int CNT_W = 4;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request handshakes plus the unified memory port
// master: requester/memory side (drives requests and mem_rdata); slave: the arbiter.
// With MEM_ARB_PERF_EN defined, the perf_*_cnt counters are carried as well.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_cnt;
   logic [31:0] perf_d_cnt;
   logic [31:0] perf_conflict_cnt;
`endif
   modport master (
      output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_wen, mem_addr, mem_wdata
`ifdef MEM_ARB_PERF_EN
      , input perf_i_cnt, perf_d_cnt, perf_conflict_cnt
`endif
   );
   modport slave (
      input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_wen, mem_addr, mem_wdata
`ifdef MEM_ARB_PERF_EN
      , output perf_i_cnt, perf_d_cnt, perf_conflict_cnt
`endif
   );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: D-priority winner select with a bounded D streak so I cannot starve
// Ports: clk, rst (sync, active-high); i_req, d_req requests; grant_en high when a grant
// may be issued this cycle; win_i, win_d one-hot winner (both 0 when no request).
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_en,
   output logic win_i,
   output logic win_d
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_D_STREAK);
   logic [CNT_W-1:0] streak_q, streak_d;
   // A D win with i_req pending only happens below LIMIT, so the increment never overflows.
   always_comb begin
      win_d    = d_req & ~(i_req & (streak_q == LIMIT));
      win_i    = i_req & ~win_d;
      streak_d = ~(grant_en & (i_req | d_req)) ? streak_q :
                 (win_d & i_req) ? streak_q + CNT_W'(1) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) streak_q <= '0;
      else     streak_q <= streak_d;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch (I) and load/store (D)
// Ports: clk (rising edge), rst (sync, active-high), bus (mem_port_arbiter_if.slave) holding
// the I/D request/grant/rvalid handshakes and the memory port. Parameters: MEM_LAT (1..15)
// read latency, MAX_D_STREAK (1..15) D grants allowed while I waits.
// Optional: define MEM_ARB_PERF_EN to add perf_i_cnt/perf_d_cnt/perf_conflict_cnt on bus.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT      = 1,
   parameter int MAX_D_STREAK = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_ACC  = ACCESS;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   owner_e           own_q, own_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic             wen_q, wen_d, st_q, st_d;
   logic             i_rv_q, i_rv_d, d_rv_q, d_rv_d;
   logic             idle, win_i, win_d, i_gnt, d_gnt, done;
   // No grant while rst is asserted: the accepting edge would be discarded by the reset.
   assign idle  = (state_q == S_IDLE) & ~rst;
   assign i_gnt = idle & win_i;
   assign d_gnt = idle & win_d;
   assign done  = (state_q == S_ACC) & (cnt_q == '0);
   mem_arb_prio #(.MAX_D_STREAK(MAX_D_STREAK)) u_prio (
      .clk      (clk),
      .rst      (rst),
      .i_req    (bus.i_req),
      .d_req    (bus.d_req),
      .grant_en (idle),
      .win_i    (win_i),
      .win_d    (win_d)
   );
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      own_d     = own_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      st_d      = st_q;
      wen_d     = 1'b0;
      i_rv_d    = done & (own_q == OWN_I);
      d_rv_d    = done & (own_q == OWN_D);
      i_rdata_d = i_rv_d ? bus.mem_rdata : i_rdata_q;
      d_rdata_d = d_rv_d ? (st_q ? '0 : bus.mem_rdata) : d_rdata_q;
      if (i_gnt | d_gnt) begin
         state_d = S_ACC;
         cnt_d   = CNT_W'(MEM_LAT - 1);
         own_d   = d_gnt ? OWN_D : OWN_I;
         addr_d  = d_gnt ? bus.d_addr : bus.i_addr;
         wdata_d = d_gnt ? bus.d_wdata : wdata_q;
         st_d    = d_gnt & bus.d_wen;
         wen_d   = d_gnt & bus.d_wen;
      end else if (state_q == S_ACC) begin
         state_d = done ? S_IDLE : S_ACC;
         cnt_d   = done ? cnt_q : cnt_q - CNT_W'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         own_q     <= OWN_I;
         addr_q    <= '0;
         wdata_q   <= '0;
         st_q      <= 1'b0;
         wen_q     <= 1'b0;
         i_rv_q    <= 1'b0;
         d_rv_q    <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         own_q     <= own_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         st_q      <= st_d;
         wen_q     <= wen_d;
         i_rv_q    <= i_rv_d;
         d_rv_q    <= d_rv_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end
   assign bus.i_gnt     = i_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.i_rvalid  = i_rv_q;
   assign bus.d_rvalid  = d_rv_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   // wen_q is only ever set at a store grant, so it marks the first ACCESS cycle of a store.
   assign bus.mem_wen   = wen_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_q, perf_d_q, perf_c_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_q <= '0;
         perf_d_q <= '0;
         perf_c_q <= '0;
      end else begin
         perf_i_q <= perf_i_q + 32'(i_gnt);
         perf_d_q <= perf_d_q + 32'(d_gnt);
         perf_c_q <= perf_c_q + 32'(idle & bus.i_req & bus.d_req);
      end
   end
   assign bus.perf_i_cnt        = perf_i_q;
   assign bus.perf_d_cnt        = perf_d_q;
   assign bus.perf_conflict_cnt = perf_c_q;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the CPU's instruction-fetch requester (I) and its load/store requester (D). Each access is accepted with a one-cycle grant, sequenced through a fixed-latency memory access, and completed with a one-cycle rvalid pulse to the winning requester. Sits between CHIP's fetch/LSU logic and the memory model. Lets a single-ported memory serve both the instruction and data address maps.

Parameters:
MEM_LAT, 1, memory read latency in cycles, counted from first address-drive cycle to rdata sample; legal range 1..15.
MAX_D_STREAK, 4, consecutive D grants allowed while i_req is pending before I is forced to win; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  32  fetch address
i_gnt  out  1  fetch accepted (1-cycle pulse)
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch data
d_req  in  1  data request; held with d_wen/d_addr/d_wdata until d_gnt
d_wen  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  data accepted (1-cycle pulse)
d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
d_rdata  out  32  load data; 0 on store completion
mem_wen  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data

Behaviour:
- Reset (rst sampled high): state IDLE, latency counter 0, streak 0, all outputs 0. Any in-flight access is dropped with no rvalid.
- FSM IDLE -> ACCESS -> IDLE.
  - IDLE: gnt is combinational, i.e. (state==IDLE) & req & winner. At the granting edge, latch addr/wen/wdata/owner, set counter to MEM_LAT-1, go to ACCESS.
  - ACCESS: mem_addr/mem_wdata are driven from the latched registers. mem_wen=1 only in the first ACCESS cycle, and only for a store.
  - When counter==0 in ACCESS: capture mem_rdata, go to IDLE. The next cycle pulses owner's rvalid with the registered rdata.
- Timing:
  - Grant at cycle t; memory address valid t+1..t+MEM_LAT; rvalid at t+MEM_LAT+1.
  - The next grant may occur in the rvalid cycle.
  - Peak throughput: one access per MEM_LAT+1 cycles.
- Arbitration:
  - D wins a simultaneous request unless streak==MAX_D_STREAK, in which case I wins.
  - streak increments on a D grant while i_req=1 (saturating). It clears on an I grant or on any D grant with i_req=0.
- Outside ACCESS: mem_wen=0; mem_addr/mem_wdata hold their last value (0 after reset). i_rdata/d_rdata hold their last value; d_rdata is 0 on store completion.
- Requests are ignored (gnt=0) while in ACCESS. Dropping req before gnt withdraws the request with no effect.
- Never both gnt outputs in one cycle; never both rvalid outputs in one cycle.

Optional Feature:
Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs perf_i_cnt, perf_d_cnt, perf_conflict_cnt (32 each).
  - They count I grants, D grants, and IDLE cycles with i_req&d_req.
  - They wrap at 2^32 and clear on rst.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, ACCESS), owner enum (OWN_I, OWN_D), counter width constant CNT_W=4.
- Optional sub-module mem_arb_prio: a combinational winner select plus the streak counter, with ports i_req, d_req, grant_en, win_i, win_d.
- The remainder is a single module.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-access with MEM_LAT=3 -> no rvalid, all outputs 0, next i_req granted on the first post-reset cycle.
2. Lone fetch: MEM_LAT=2, i_req addr 0x00400004, mem returns 0x00000013 -> i_gnt at t, mem_addr=0x00400004 on t+1..t+2, i_rvalid with i_rdata=0x00000013 at t+3.
3. Store then load, same address: store 0xDEADBEEF to 0x10010008 -> mem_wen=1 for exactly one cycle, d_rvalid with d_rdata=0; subsequent load returns 0xDEADBEEF.
4. Simultaneous requests, MAX_D_STREAK=4: d_req and i_req held high -> D granted 4 times, then I once, then the pattern repeats; no double grants.
5. Back-to-back: MEM_LAT=1, continuous d_req -> d_gnt every 2 cycles, each rvalid coincides with the next gnt.
6. MEM_ARB_PERF_EN defined, scenario 4 run for 10 grants -> perf_d_cnt=8, perf_i_cnt=2, perf_conflict_cnt=10.
